// File: rtl/prog_loader_pkg.sv
// loader_pkg: shared states and sizing constants for the boot program loader.
package loader_pkg;
   localparam int HDR_BYTES = 4;
   localparam int WORD_BYTES = 4;
   localparam int CNT_W = 16;
   typedef enum logic [3:0] {HDR0, HDR1, HDR2, HDR3, DATA, WRITE, CHK, DONE, ERR} state_t;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream, CPU RAM port, RAM port and status bundle of the loader.
interface prog_loader_if #(parameter int SIZE = 14);
   logic            in_valid;
   logic [7:0]      in_data;
   logic            in_ready;
   logic            cpu_wrEn;
   logic [SIZE-1:0] cpu_addr;
   logic [31:0]     cpu_data;
   logic            ram_we;
   logic [SIZE-1:0] ram_addr;
   logic [31:0]     ram_data;
   logic            cpu_rst;
   logic            done;
   logic            err;
   modport slave (input in_valid, in_data, cpu_wrEn, cpu_addr, cpu_data,
                  output in_ready, ram_we, ram_addr, ram_data, cpu_rst, done, err);
   modport master (output in_valid, in_data, cpu_wrEn, cpu_addr, cpu_data,
                   input in_ready, ram_we, ram_addr, ram_data, cpu_rst, done, err);
endinterface

// File: rtl/prog_loader_word_asm.sv
// loader_word_asm: shifts bytes MSB-first into a 32-bit word, pulses word_rdy on the 4th byte.
module loader_word_asm
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        push,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        word_rdy
);
   logic [$clog2(WORD_BYTES)-1:0] idx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         word <= '0;
         idx <= '0;
      end else if (start) begin
         word <= '0;
         idx <= '0;
      end else if (push) begin
         word <= {word[23:0], din};
         idx <= idx + 1'b1;
      end
   assign word_rdy = push & (&idx);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot loader writing a framed byte stream into RAM, then passing the CPU port through.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
   import loader_pkg::*;
#(
   parameter int SIZE = 14
) (
   input logic          clk,
   input logic          rst,
   prog_loader_if.slave bus
);
`ifdef LOADER_CHECKSUM_EN
   localparam state_t FIN = CHK;
`else
   localparam state_t FIN = DONE;
`endif
   state_t           state;
   logic             in_ready, we, done, acc, word_rdy;
   logic [SIZE-1:0]  addr;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [31:0]      word;
   assign acc = bus.in_valid & in_ready;
   assign cnt_nx = {cnt[7:0], bus.in_data};
   loader_word_asm u_asm (
      .clk,
      .rst,
      .start    (acc & (state == HDR3)),
      .push     (acc & (state == DATA)),
      .din      (bus.in_data),
      .word,
      .word_rdy
   );
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic       err;
   always_ff @(posedge clk or posedge rst)
      if (rst) sum <= '0;
      else if (acc) sum <= sum + bus.in_data;
`else
   logic err;
   assign err = 1'b0;
`endif
   // The address register doubles as the RAM address while loading.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= HDR0;
         in_ready <= 1'b0;
         we <= 1'b0;
         done <= 1'b0;
         addr <= '0;
         cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
         err <= 1'b0;
`endif
      end else begin
         case (state)
            HDR0, HDR1: begin
               in_ready <= 1'b1;
               if (acc) begin
                  addr <= {addr[SIZE-9:0], bus.in_data};
                  state <= state == HDR0 ? HDR1 : HDR2;
               end
            end
            HDR2: if (acc) begin
               cnt <= cnt_nx;
               state <= HDR3;
            end
            HDR3: if (acc) begin
               cnt <= cnt_nx;
               if (cnt_nx == '0) begin
                  state <= FIN;
                  in_ready <= FIN == CHK;
                  done <= FIN == DONE;
               end else state <= DATA;
            end
            DATA: if (word_rdy) begin
               state <= WRITE;
               we <= 1'b1;
               in_ready <= 1'b0;
            end
            WRITE: begin
               we <= 1'b0;
               addr <= addr + 1'b1;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= FIN;
                  in_ready <= FIN == CHK;
                  done <= FIN == DONE;
               end else begin
                  state <= DATA;
                  in_ready <= 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: if (acc) begin
               in_ready <= 1'b0;
               if (sum + bus.in_data == 8'h00) begin
                  state <= DONE;
                  done <= 1'b1;
               end else begin
                  state <= ERR;
                  err <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   assign bus.in_ready = in_ready;
   assign bus.ram_we   = done ? bus.cpu_wrEn : we;
   assign bus.ram_addr = done ? bus.cpu_addr : addr;
   assign bus.ram_data = done ? bus.cpu_data : word;
   assign bus.cpu_rst  = ~done;
   assign bus.done     = done;
   assign bus.err      = err;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames checked against hand-computed RAM writes and handshake timing.
module tb_prog_loader;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   int compared = 0, mism = 0, gap_max = 0, wr_total = 0, b;
   logic [7:0] csum = 8'h00;
   logic [13:0] wa [4096];
   logic [31:0] wd [4096];
   prog_loader_if #(.SIZE(14)) bus ();
   prog_loader #(.SIZE(14)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   always @(negedge clk)
      if (bus.ram_we === 1'b1) begin
         wa[wr_total] <= bus.ram_addr;
         wd[wr_total] <= bus.ram_data;
         wr_total <= wr_total + 1;
      end
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [7:0] v);
      int t;
      t = 0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = v;
      while (bus.in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("send_ready", {31'b0, bus.in_ready}, 1);
      else begin
         @(posedge clk);
         #1;
         csum = csum + v;
      end
      bus.in_valid = 1'b0;
   endtask
   task automatic send_hdr(input logic [15:0] a, input logic [15:0] c);
      csum = 8'h00;
      send(a[15:8]); send(a[7:0]); send(c[15:8]); send(c[7:0]);
   endtask
   task automatic send_word(input logic [31:0] w);
      send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
   endtask
   task automatic send_ck(input logic [7:0] delta);
      if (CK) send(8'h00 - csum + delta);
   endtask
   task automatic wait_done();
      int t;
      t = 0;
      while (bus.done !== 1'b1 && t < 30) begin
         @(negedge clk);
         t++;
      end
      chk("done_wait", {31'b0, bus.done}, 1);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.cpu_wrEn = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #2;
      b = wr_total;
   endtask
   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0;
      bus.cpu_wrEn = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_ram_data", bus.ram_data, 0);
      chk("rst_cpu_rst", bus.cpu_rst, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      rst = 1'b0;
      #1 chk("post_rst_ready_low", bus.in_ready, 0);
      @(negedge clk) chk("post_rst_ready_high", bus.in_ready, 1);
      b = wr_total;
      // frame 1 with per-cycle timing of both writes
      send_hdr(16'h0000, 16'h0002);
      send_word(32'h809601F4);
      @(negedge clk);
      chk("w0_we", bus.ram_we, 1);
      chk("w0_addr", bus.ram_addr, 0);
      chk("w0_data", bus.ram_data, 32'h809601F4);
      chk("w0_ready_low", bus.in_ready, 0);
      @(negedge clk);
      chk("w0_we_drop", bus.ram_we, 0);
      chk("w0_ready_back", bus.in_ready, 1);
      send_word(32'h80078258);
      @(negedge clk);
      chk("w1_we", bus.ram_we, 1);
      chk("w1_addr", bus.ram_addr, 1);
      chk("w1_data", bus.ram_data, 32'h80078258);
      chk("w1_done_low", bus.done, 0);
      chk("w1_cpu_rst", bus.cpu_rst, 1);
      @(negedge clk);
      chk("f1_done_edge", bus.done, CK ? 0 : 1);
      chk("f1_cpu_rst_edge", bus.cpu_rst, CK ? 1 : 0);
      chk("f1_ready_edge", bus.in_ready, CK ? 1 : 0);
      send_ck(8'h00);
      wait_done();
      chk("f1_cpu_rst", bus.cpu_rst, 0);
      chk("f1_err", bus.err, 0);
      chk("f1_count", wr_total - b, 2);
      chk("f1_a0", wa[b], 0);
      chk("f1_d0", wd[b], 32'h809601F4);
      chk("f1_a1", wa[b+1], 1);
      chk("f1_d1", wd[b+1], 32'h80078258);
      @(negedge clk);
      bus.cpu_wrEn = 1'b1; bus.cpu_addr = 14'h1234; bus.cpu_data = 32'hDEADBEEF;
      #1;
      chk("pt_we", bus.ram_we, 1);
      chk("pt_addr", bus.ram_addr, 14'h1234);
      chk("pt_data", bus.ram_data, 32'hDEADBEEF);
      bus.cpu_wrEn = 1'b0; bus.cpu_addr = 14'h0ABC; bus.cpu_data = 32'h01234567;
      #1;
      chk("pt_we0", bus.ram_we, 0);
      chk("pt_addr2", bus.ram_addr, 14'h0ABC);
      chk("pt_data2", bus.ram_data, 32'h01234567);
      bus.in_valid = 1'b1; bus.in_data = 8'h55;
      repeat (5) @(negedge clk);
      chk("done_ready_low", bus.in_ready, 0);
      chk("done_sticky", bus.done, 1);
      bus.in_valid = 1'b0;
      // single word at 500, one-cycle write strobe
      do_reset();
      send_hdr(16'h01F4, 16'h0001);
      send_word(32'h00000008);
      @(negedge clk);
      chk("f2_we", bus.ram_we, 1);
      chk("f2_addr", bus.ram_addr, 14'd500);
      chk("f2_data", bus.ram_data, 32'h00000008);
      @(negedge clk);
      chk("f2_we_one_cycle", bus.ram_we, 0);
      send_ck(8'h00);
      wait_done();
      chk("f2_count", wr_total - b, 1);
      // address wrap 3FFF -> 0000, upper address bits ignored
      do_reset();
      send_hdr(16'hFFFF, 16'h0002);
      send_word(32'h11111111);
      send_word(32'h22222222);
      send_ck(8'h00);
      wait_done();
      chk("f3_count", wr_total - b, 2);
      chk("f3_a0", wa[b], 14'h3FFF);
      chk("f3_a1", wa[b+1], 14'h0000);
      chk("f3_d1", wd[b+1], 32'h22222222);
      // random gaps with junk on the CPU port, which must be ignored
      do_reset();
      gap_max = 3;
      bus.cpu_wrEn = 1'b1; bus.cpu_addr = 14'h0003; bus.cpu_data = 32'hBADBAD00;
      send_hdr(16'h0010, 16'h0003);
      send_word(32'hA1B2C3D4);
      send_word(32'h00FF00FF);
      send_word(32'hCAFEF00D);
      send_ck(8'h00);
      wait_done();
      bus.cpu_wrEn = 1'b0;
      gap_max = 0;
      chk("f4_a0", wa[b], 14'h0010);
      chk("f4_d0", wd[b], 32'hA1B2C3D4);
      chk("f4_a1", wa[b+1], 14'h0011);
      chk("f4_d1", wd[b+1], 32'h00FF00FF);
      chk("f4_a2", wa[b+2], 14'h0012);
      chk("f4_d2", wd[b+2], 32'hCAFEF00D);
      // reset after 2 of 3 words, then a full frame
      do_reset();
      send_hdr(16'h0020, 16'h0003);
      send_word(32'h0000000A);
      send_word(32'h0000000B);
      repeat (3) @(negedge clk);
      chk("f5_partial_count", wr_total - b, 2);
      chk("f5_partial_a1", wa[b+1], 14'h0021);
      chk("f5_partial_cpu_rst", bus.cpu_rst, 1);
      rst = 1'b1;
      #1;
      chk("f5_rst_ready", bus.in_ready, 0);
      chk("f5_rst_cpu_rst", bus.cpu_rst, 1);
      @(negedge clk);
      rst = 1'b0;
      #2 b = wr_total;
      send_hdr(16'h0040, 16'h0003);
      send_word(32'h0000000C);
      send_word(32'h0000000D);
      chk("f5_cpu_rst_held", bus.cpu_rst, 1);
      send_word(32'h0000000E);
      send_ck(8'h00);
      wait_done();
      chk("f5_count", wr_total - b, 3);
      chk("f5_a0", wa[b], 14'h0040);
      chk("f5_d0", wd[b], 32'h0000000C);
      chk("f5_a2", wa[b+2], 14'h0042);
      chk("f5_d2", wd[b+2], 32'h0000000E);
      // zero-length frame
      do_reset();
      send_hdr(16'h0005, 16'h0000);
      send_ck(8'h00);
      wait_done();
      chk("f6_count", wr_total - b, 0);
`ifdef LOADER_CHECKSUM_EN
      do_reset();
      send_hdr(16'h0000, 16'h0002);
      send_word(32'h809601F4);
      send_word(32'h80078258);
      repeat (2) @(negedge clk);
      b = wr_total;
      send_ck(8'h01);
      @(negedge clk);
      chk("ck_err", bus.err, 1);
      chk("ck_cpu_rst", bus.cpu_rst, 1);
      chk("ck_ready", bus.in_ready, 0);
      chk("ck_done", bus.done, 0);
      bus.in_valid = 1'b1; bus.in_data = 8'h00;
      repeat (5) @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ck_no_writes", wr_total - b, 0);
      chk("ck_err_sticky", bus.err, 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule
